bitslam_reg_writer: RTL



---
 rtl/bitslam_pkg.sv | 22 ++
 rtl/bitslam_req_fifo.sv | 51 +++++
 rtl/bitslam_reg_writer.sv | 114 +++++++++++
 3 files changed

// File: rtl/bitslam_pkg.sv
// Shared constants and types for the bitslam register-write bus master.
package bitslam_pkg;

  localparam int unsigned DEFAULT_DATA_W = 6;
  localparam int unsigned DEFAULT_ADDR_W = 2;

  localparam logic REG_CLK_DIV  = 1'b0;
  localparam logic REG_TAP_MASK = 1'b1;
  localparam logic VOICE0       = 1'b0;
  localparam logic VOICE1       = 1'b1;

  localparam logic BUS_SEL_ADDR = 1'b0;
  localparam logic BUS_SEL_DATA = 1'b1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/bitslam_req_fifo.sv
// Request FIFO with head output plus a peek at the entry behind the head.
module bitslam_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [WIDTH-1:0]        second,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = count_q[PTR_W];
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign second  = mem[rd_ptr_q + PTR_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bitslam_reg_writer.sv
// Write-side bus master for the bitslam core: queues register writes and issues
// address/data bus cycles, skipping the address phase when the core already holds it.
module bitslam_reg_writer
  import bitslam_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_voice,
  input  logic              req_reg,
  input  logic [DATA_W-1:0] req_data,
  output logic              bus_sel,
  output logic [DATA_W-1:0] bus_val,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              addr_known_q, addr_known_d;
  logic              bus_sel_d, busy_d;
  logic [DATA_W-1:0] bus_val_d;

  req_t             din, head, second, nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop, full, empty, nxt_valid;

  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign din       = '{addr: {req_voice, req_reg}, data: req_data};

  bitslam_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (din),
    .dout   (head),
    .second (second),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Outputs are registered, so they are computed from the state being entered
  // and from the entry that will be at the head during that state.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    addr_known_d = addr_known_q;
    pop          = 1'b0;
    nxt          = head;
    nxt_valid    = !empty;

    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = (addr_known_q && head.addr == cur_addr_q) ? DATA : ADDR;
      end
      ADDR: state_d = DATA;
      DATA: begin
        pop       = 1'b1;
        nxt       = (count > CNT_W'(1)) ? second : din;
        nxt_valid = (count > CNT_W'(1)) || push;
        if (!nxt_valid)                    state_d = IDLE;
        else if (nxt.addr == cur_addr_q)   state_d = DATA;
        else                               state_d = ADDR;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ADDR) begin
      cur_addr_d   = nxt.addr;
      addr_known_d = 1'b1;
    end

    bus_sel_d = BUS_SEL_ADDR;
    bus_val_d = {{(DATA_W - ADDR_W){1'b0}}, cur_addr_d};
    if (state_d == DATA) begin
      bus_sel_d = BUS_SEL_DATA;
      bus_val_d = nxt.data;
    end

    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    busy_d    = (state_d != IDLE) || (count_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      addr_known_q <= 1'b0;
      bus_sel      <= BUS_SEL_ADDR;
      bus_val      <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      addr_known_q <= addr_known_d;
      bus_sel      <= bus_sel_d;
      bus_val      <= bus_val_d;
      busy         <= busy_d;
    end
  end

endmodule
